oam_dma_arbiter: RTL and testbench
==================================

OAM_DMA_ARBITER -- requirements
Module: oam_dma_arbiter

Interface
REQ-001 SHALL have parameter DMA_LEN, default 160, meaning bytes per OAM DMA transfer.
REQ-002 SHALL have parameter OAM_BASE, default 16'hFE00, meaning first OAM destination address.
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  in  1  reset; one clock; reset is asynchronous and active-low.
REQ-005 SHALL have ports ADDR in 16, WR in 1, RD in 1, MMIO_DATA_out in 8: CPU address, write strobe, read strobe, write data.
REQ-006 SHALL have port CPU_DATA_in  out  8  read data returned to CPU.
REQ-007 SHALL have ports PPU_MODE in 2, PPU_RD in 1, PPU_ADDR in 16: PPU mode, read strobe, address.
REQ-008 SHALL have port PPU_DATA_in  out  8  read data returned to PPU.
REQ-009 SHALL have ports DMA_RD out 1, DMA_SRC_ADDR out 16, DMA_SRC_DATA in 8: DMA source-bus read port; data valid the cycle after DMA_RD.
REQ-010 SHALL have ports MEM_ADDR out 16, MEM_WE out 1, MEM_WDATA out 8, MEM_RDATA in 8: shared VRAM/OAM single port; MEM_RDATA valid the cycle after address.
REQ-011 SHALL have port DMA_ACTIVE  out  1  high while a transfer is in progress.

Function
REQ-012 SHALL decode regions: VRAM 8000-9FFF, OAM FE00-FE9F, unusable FEA0-FEFF; all other addresses are ignored.
REQ-013 SHALL decode PPU_MODE as H_BLANK=0, V_BLANK=1, SCAN=2, DRAW=3.
REQ-014 SHALL, on WR to FF46, latch MMIO_DATA_out as source high byte, reset byte index to 0, and enter START.
REQ-015 SHALL sequence DMA states IDLE -> START (1 cycle) -> RD -> WR -> RD ... -> IDLE; 2 cycles per byte.
REQ-016 SHALL in RD assert DMA_RD with DMA_SRC_ADDR = {src_hi, index}.
REQ-017 SHALL in WR drive MEM_WE=1, MEM_ADDR=OAM_BASE+index, MEM_WDATA=DMA_SRC_DATA, then increment index.
REQ-018 SHALL return to IDLE after the write of index DMA_LEN-1; full transfer = 1 + 2*DMA_LEN cycles (321 at default).
REQ-019 SHALL restart from index 0 with the new source when FF46 is written during an active transfer; there is no gap cycle beyond START.
REQ-020 SHALL grant the memory port with priority: DMA write > PPU read > CPU access; exactly one owner per cycle.
REQ-021 SHALL grant a PPU read only for OAM in SCAN or for VRAM/OAM in DRAW.
REQ-022 SHALL block a CPU access to OAM when PPU_MODE is SCAN or DRAW, or while DMA_ACTIVE.
REQ-023 SHALL block a CPU access to VRAM when PPU_MODE is DRAW.
REQ-024 SHALL drop blocked CPU writes and return 8'hFF for blocked CPU reads.
REQ-025 SHALL return 8'hFF for a PPU OAM read issued while DMA_ACTIVE.
REQ-026 SHALL return 8'h00 for CPU reads of the unusable region and ignore writes to it.
REQ-027 SHALL register the owner and request type each cycle, and steer MEM_RDATA the following cycle to CPU_DATA_in or PPU_DATA_in.
REQ-028 SHALL hold each of CPU_DATA_in and PPU_DATA_in at its last value until its next granted read completes.
REQ-029 SHALL drive MEM_WE=0 and MEM_ADDR=0 in cycles with no owner.
REQ-030 SHALL give precedence to the FF46 restart when an FF46 write coincides with the final DMA write; that final write still completes.

Reset
REQ-031 SHALL, on reset, set DMA state IDLE, index 0, src_hi 0, DMA_ACTIVE 0, DMA_RD 0, MEM_WE 0, MEM_ADDR 0, MEM_WDATA 0, CPU_DATA_in 8'hFF, PPU_DATA_in 8'hFF, owner none.
REQ-032 SHALL abort any transfer on reset assertion mid-DMA, leaving OAM partially written with no further writes.

Structure
REQ-033 SHALL take PPU mode enum, DMA state enum, region bounds and the FF46 address from a shared package, ppu_pkg.
REQ-034 SHALL contain one sub-module, oam_dma_seq, holding the DMA state machine and index counter; arbitration stays in the top level.

Verification
REQ-035 SHALL cover: WR FF46=8'hC0 in H_BLANK -> OAM FE00..FE9F equals C000..C09F after 321 cycles; DMA_ACTIVE falls on cycle 322.
REQ-036 SHALL cover: CPU RD FE10 during DMA -> CPU_DATA_in=8'hFF; CPU RD 8000 during DMA in H_BLANK -> real VRAM data.
REQ-037 SHALL cover: PPU_MODE=DRAW, CPU WR 9800=8'h55 -> memory unchanged; repeat in H_BLANK -> 9800 reads 8'h55.
REQ-038 SHALL cover: FF46=8'hC0, then FF46=8'hD0 at index 50 -> all 160 OAM bytes from D000..D09F.
REQ-039 SHALL cover: PPU read FE04 and CPU read 8000 in same SCAN cycle -> PPU served next cycle, CPU gets 8'hFF.
REQ-040 SHALL cover: rst low at index 80 -> outputs reach reset values immediately (asynchronous), FE50..FE9F untouched.

Source files
------------

// File: rtl/ppu_pkg.sv
// Shared PPU/DMA definitions: PPU mode and DMA state encodings, memory map
// bounds, and the memory-port ownership and read-response types.
package ppu_pkg;

  typedef enum logic [1:0] {
    H_BLANK = 2'd0,
    V_BLANK = 2'd1,
    SCAN    = 2'd2,
    DRAW    = 2'd3
  } ppu_mode_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_RD    = 2'd2,
    ST_WR    = 2'd3
  } dma_state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_DMA  = 2'd1,
    OWN_PPU  = 2'd2,
    OWN_CPU  = 2'd3
  } owner_t;

  // What a read request turns into one cycle later.
  typedef enum logic [1:0] {
    RSP_NONE = 2'd0,
    RSP_MEM  = 2'd1,
    RSP_FF   = 2'd2,
    RSP_ZERO = 2'd3
  } rsp_t;

  localparam logic [15:0] VRAM_LO      = 16'h8000;
  localparam logic [15:0] VRAM_HI      = 16'h9FFF;
  localparam logic [15:0] OAM_LO       = 16'hFE00;
  localparam logic [15:0] OAM_HI       = 16'hFE9F;
  localparam logic [15:0] UNUSABLE_LO  = 16'hFEA0;
  localparam logic [15:0] UNUSABLE_HI  = 16'hFEFF;
  localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;

  function automatic logic in_range(input logic [15:0] a, input logic [15:0] lo,
                                    input logic [15:0] hi);
    return (a >= lo) && (a <= hi);
  endfunction

endpackage

// File: rtl/oam_dma_seq.sv
// OAM DMA sequencer: START, then alternating source-read / OAM-write cycles
// per byte. A new start request restarts from byte 0 in any state.
module oam_dma_seq import ppu_pkg::*; #(
  parameter int DMA_LEN = 160
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] src,
  output dma_state_t state,
  output logic [7:0] index,
  output logic [7:0] src_hi
);

  localparam logic [7:0] LAST_IDX = 8'(DMA_LEN - 1);

  dma_state_t state_d;
  logic [7:0] index_d;
  logic [7:0] src_hi_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= ST_IDLE;
      index  <= '0;
      src_hi <= '0;
    end else begin
      state  <= state_d;
      index  <= index_d;
      src_hi <= src_hi_d;
    end
  end

  always_comb begin
    state_d  = state;
    index_d  = index;
    src_hi_d = src_hi;
    case (state)
      ST_START: state_d = ST_RD;
      ST_RD:    state_d = ST_WR;
      ST_WR: begin
        index_d = index + 8'd1;
        state_d = (index == LAST_IDX) ? ST_IDLE : ST_RD;
      end
      default: ;
    endcase
    // A restart wins over everything, including the last byte's write cycle.
    if (start) begin
      state_d  = ST_START;
      index_d  = '0;
      src_hi_d = src;
    end
  end

endmodule

// File: rtl/oam_dma_arbiter.sv
// VRAM/OAM single-port arbiter with OAM DMA engine. Priority is DMA write,
// then PPU read, then CPU access; read data is steered back a cycle later.
module oam_dma_arbiter import ppu_pkg::*; #(
  parameter int          DMA_LEN  = 160,
  parameter logic [15:0] OAM_BASE = 16'hFE00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ADDR,
  input  logic        WR,
  input  logic        RD,
  input  logic [7:0]  MMIO_DATA_out,
  output logic [7:0]  CPU_DATA_in,
  input  logic [1:0]  PPU_MODE,
  input  logic        PPU_RD,
  input  logic [15:0] PPU_ADDR,
  output logic [7:0]  PPU_DATA_in,
  output logic        DMA_RD,
  output logic [15:0] DMA_SRC_ADDR,
  input  logic [7:0]  DMA_SRC_DATA,
  output logic [15:0] MEM_ADDR,
  output logic        MEM_WE,
  output logic [7:0]  MEM_WDATA,
  input  logic [7:0]  MEM_RDATA,
  output logic        DMA_ACTIVE
);

  ppu_mode_t  mode;
  dma_state_t dma_state;
  logic [7:0] dma_index;
  logic [7:0] src_hi;
  logic       ff46_wr;
  logic       port_en;
  logic       ppu_oam, ppu_vram, ppu_ok, ppu_dma_blk;
  logic       cpu_oam, cpu_vram, cpu_unus, cpu_mem, cpu_rd, cpu_blocked;
  owner_t     owner, owner_p1;
  rsp_t       cpu_rsp, cpu_rsp_p1;
  rsp_t       ppu_rsp, ppu_rsp_p1;
  logic [7:0] cpu_hold, ppu_hold;

  assign mode    = ppu_mode_t'(PPU_MODE);
  assign ff46_wr = WR && (ADDR == DMA_REG_ADDR);

  oam_dma_seq #(.DMA_LEN(DMA_LEN)) u_seq (
    .clk    (clk),
    .rst    (rst),
    .start  (ff46_wr),
    .src    (MMIO_DATA_out),
    .state  (dma_state),
    .index  (dma_index),
    .src_hi (src_hi)
  );

  assign DMA_ACTIVE   = (dma_state != ST_IDLE);
  assign DMA_RD       = (dma_state == ST_RD);
  assign DMA_SRC_ADDR = {src_hi, dma_index};

  assign ppu_oam     = in_range(PPU_ADDR, OAM_LO, OAM_HI);
  assign ppu_vram    = in_range(PPU_ADDR, VRAM_LO, VRAM_HI);
  assign ppu_ok      = PPU_RD && (((mode == SCAN) && ppu_oam) ||
                                  ((mode == DRAW) && (ppu_oam || ppu_vram)));
  assign ppu_dma_blk = ppu_oam && DMA_ACTIVE;

  assign cpu_oam     = in_range(ADDR, OAM_LO, OAM_HI);
  assign cpu_vram    = in_range(ADDR, VRAM_LO, VRAM_HI);
  assign cpu_unus    = in_range(ADDR, UNUSABLE_LO, UNUSABLE_HI);
  assign cpu_mem     = (WR || RD) && (cpu_oam || cpu_vram);
  assign cpu_rd      = RD && !WR;
  assign cpu_blocked = (cpu_oam && ((mode == SCAN) || (mode == DRAW) || DMA_ACTIVE)) ||
                       (cpu_vram && (mode == DRAW));

  // Keeps the port ownerless from reset assertion until the first clock after release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) port_en <= 1'b0;
    else      port_en <= 1'b1;
  end

  always_comb begin
    owner     = OWN_NONE;
    cpu_rsp   = RSP_NONE;
    ppu_rsp   = RSP_NONE;
    MEM_ADDR  = '0;
    MEM_WE    = 1'b0;
    MEM_WDATA = '0;
    if (port_en) begin
      if (dma_state == ST_WR)          owner = OWN_DMA;
      else if (ppu_ok && !ppu_dma_blk) owner = OWN_PPU;
      else if (cpu_mem && !cpu_blocked) owner = OWN_CPU;
    end
    // Reads that are blocked or lose arbitration answer 8'hFF.
    if (ppu_ok) ppu_rsp = (owner == OWN_PPU) ? RSP_MEM : RSP_FF;
    if (cpu_rd) begin
      if (cpu_unus)     cpu_rsp = RSP_ZERO;
      else if (cpu_mem) cpu_rsp = (owner == OWN_CPU) ? RSP_MEM : RSP_FF;
    end
    case (owner)
      OWN_DMA: begin
        MEM_ADDR  = OAM_BASE + {8'h00, dma_index};
        MEM_WE    = 1'b1;
        MEM_WDATA = DMA_SRC_DATA;
      end
      OWN_PPU: MEM_ADDR = PPU_ADDR;
      OWN_CPU: begin
        MEM_ADDR  = ADDR;
        MEM_WE    = WR;
        MEM_WDATA = WR ? MMIO_DATA_out : 8'h00;
      end
      default: ;
    endcase
  end

  // p0 -> p1: owner and response kind, consumed when MEM_RDATA arrives
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_p1   <= OWN_NONE;
      cpu_rsp_p1 <= RSP_NONE;
      ppu_rsp_p1 <= RSP_NONE;
      cpu_hold   <= 8'hFF;
      ppu_hold   <= 8'hFF;
    end else begin
      owner_p1   <= owner;
      cpu_rsp_p1 <= cpu_rsp;
      ppu_rsp_p1 <= ppu_rsp;
      cpu_hold   <= CPU_DATA_in;
      ppu_hold   <= PPU_DATA_in;
    end
  end

  always_comb begin
    CPU_DATA_in = cpu_hold;
    case (cpu_rsp_p1)
      RSP_MEM:  if (owner_p1 == OWN_CPU) CPU_DATA_in = MEM_RDATA;
      RSP_FF:   CPU_DATA_in = 8'hFF;
      RSP_ZERO: CPU_DATA_in = 8'h00;
      default: ;
    endcase
  end

  always_comb begin
    PPU_DATA_in = ppu_hold;
    case (ppu_rsp_p1)
      RSP_MEM: if (owner_p1 == OWN_PPU) PPU_DATA_in = MEM_RDATA;
      RSP_FF:  PPU_DATA_in = 8'hFF;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// Bench for oam_dma_arbiter: models the shared memory and DMA source bus,
// queues expected read responses and compares them a cycle later.
module tb_oam_dma_arbiter;
  import ppu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] ADDR;
  logic        WR, RD;
  logic [7:0]  MMIO_DATA_out;
  logic [7:0]  CPU_DATA_in;
  logic [1:0]  PPU_MODE;
  logic        PPU_RD;
  logic [15:0] PPU_ADDR;
  logic [7:0]  PPU_DATA_in;
  logic        DMA_RD;
  logic [15:0] DMA_SRC_ADDR;
  logic [7:0]  DMA_SRC_DATA = 8'h00;
  logic [15:0] MEM_ADDR;
  logic        MEM_WE;
  logic [7:0]  MEM_WDATA;
  logic [7:0]  MEM_RDATA = 8'h00;
  logic        DMA_ACTIVE;

  oam_dma_arbiter #(.DMA_LEN(160), .OAM_BASE(16'hFE00)) dut (
    .clk(clk), .rst(rst), .ADDR(ADDR), .WR(WR), .RD(RD),
    .MMIO_DATA_out(MMIO_DATA_out), .CPU_DATA_in(CPU_DATA_in),
    .PPU_MODE(PPU_MODE), .PPU_RD(PPU_RD), .PPU_ADDR(PPU_ADDR),
    .PPU_DATA_in(PPU_DATA_in), .DMA_RD(DMA_RD), .DMA_SRC_ADDR(DMA_SRC_ADDR),
    .DMA_SRC_DATA(DMA_SRC_DATA), .MEM_ADDR(MEM_ADDR), .MEM_WE(MEM_WE),
    .MEM_WDATA(MEM_WDATA), .MEM_RDATA(MEM_RDATA), .DMA_ACTIVE(DMA_ACTIVE)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] src_fn(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  function automatic logic [7:0] vram_fn(input logic [15:0] a);
    return a[7:0] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] init_fn(input logic [15:0] a);
    if (a >= 16'h8000 && a <= 16'h9FFF) return vram_fn(a);
    if (a == 16'hFEA0) return 8'h77;
    return 8'h00;
  endfunction

  logic [7:0] mem [0:65535];
  logic       preload = 1'b1;

  always @(posedge clk) begin
    if (preload) begin
      for (int a = 0; a < 65536; a++) mem[a] <= init_fn(16'(a));
    end else if (MEM_WE) begin
      mem[MEM_ADDR] <= MEM_WDATA;
    end
    MEM_RDATA <= mem[MEM_ADDR];
    if (DMA_RD) DMA_SRC_DATA <= src_fn(DMA_SRC_ADDR);
  end

  string      cpu_tag_q[$];
  logic [7:0] cpu_exp_q[$];
  string      ppu_tag_q[$];
  logic [7:0] ppu_exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int dcyc  = 0;

  task automatic check_val(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    dcyc++;
    WR = 1'b0;
    RD = 1'b0;
    PPU_RD = 1'b0;
    while (cpu_exp_q.size() > 0) begin
      string t;
      logic [7:0] e;
      t = cpu_tag_q.pop_front();
      e = cpu_exp_q.pop_front();
      check_val(t, {8'h00, CPU_DATA_in}, {8'h00, e});
    end
    while (ppu_exp_q.size() > 0) begin
      string t;
      logic [7:0] e;
      t = ppu_tag_q.pop_front();
      e = ppu_exp_q.pop_front();
      check_val(t, {8'h00, PPU_DATA_in}, {8'h00, e});
    end
  endtask

  task automatic cpu_rd_req(input logic [15:0] a, input logic [7:0] e, input string t);
    ADDR = a;
    RD = 1'b1;
    cpu_tag_q.push_back(t);
    cpu_exp_q.push_back(e);
  endtask

  task automatic ppu_rd_req(input logic [15:0] a, input logic [7:0] e, input string t);
    PPU_ADDR = a;
    PPU_RD = 1'b1;
    ppu_tag_q.push_back(t);
    ppu_exp_q.push_back(e);
  endtask

  task automatic cpu_wr(input logic [15:0] a, input logic [7:0] d);
    ADDR = a;
    MMIO_DATA_out = d;
    WR = 1'b1;
    tick();
  endtask

  task automatic dma_start(input logic [7:0] s);
    ADDR = 16'hFF46;
    MMIO_DATA_out = s;
    WR = 1'b1;
    dcyc = 0;
    tick();
  endtask

  task automatic check_oam(input logic [7:0] page, input string t);
    for (int i = 0; i < 160; i++)
      check_val(t, {8'h00, mem[16'hFE00 + 16'(i)]}, {8'h00, src_fn({page, 8'(i)})});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    ADDR = '0; WR = 1'b0; RD = 1'b0; MMIO_DATA_out = '0;
    PPU_MODE = H_BLANK; PPU_RD = 1'b0; PPU_ADDR = '0;
    tick();
    tick();
    preload = 1'b0;
    check_val("rst_cpu_data", {8'h00, CPU_DATA_in}, 16'h00FF);
    check_val("rst_ppu_data", {8'h00, PPU_DATA_in}, 16'h00FF);
    check_val("rst_dma_active", {15'h0, DMA_ACTIVE}, 16'h0);
    check_val("rst_dma_rd", {15'h0, DMA_RD}, 16'h0);
    check_val("rst_mem_we", {15'h0, MEM_WE}, 16'h0);
    check_val("rst_mem_addr", MEM_ADDR, 16'h0);
    check_val("rst_mem_wdata", {8'h00, MEM_WDATA}, 16'h0);
    check_val("rst_src_addr", DMA_SRC_ADDR, 16'h0);
    rst = 1'b1;
    tick();
    tick();
    check_val("idle_mem_addr", MEM_ADDR, 16'h0);
    check_val("idle_mem_we", {15'h0, MEM_WE}, 16'h0);

    // Plain CPU traffic, unusable region and unmapped addresses
    cpu_rd_req(16'h8001, 8'h5B, "cpu_vram_rd"); tick();
    cpu_wr(16'hFE9F, 8'hA5);
    cpu_rd_req(16'hFE9F, 8'hA5, "cpu_oam_rdback"); tick();
    cpu_rd_req(16'hFEA0, 8'h00, "cpu_unusable_rd"); tick();
    cpu_wr(16'hFEA0, 8'h11);
    check_val("unusable_wr_ignored", {8'h00, mem[16'hFEA0]}, 16'h0077);
    cpu_rd_req(16'hC123, 8'h00, "cpu_unmapped_hold"); tick();

    // PPU eligibility and same-cycle PPU/CPU contention in SCAN
    ppu_rd_req(16'hFE04, 8'hFF, "ppu_hblank_ignored"); tick();
    PPU_MODE = SCAN;
    ppu_rd_req(16'hFE04, 8'h00, "ppu_scan_oam");
    cpu_rd_req(16'h8000, 8'hFF, "cpu_loses_to_ppu"); tick();
    PPU_MODE = DRAW;
    ppu_rd_req(16'h8003, 8'h59, "ppu_draw_vram"); tick();
    PPU_MODE = SCAN;
    ppu_rd_req(16'h8003, 8'h59, "ppu_scan_vram_hold"); tick();

    // VRAM lockout during DRAW
    PPU_MODE = DRAW;
    cpu_wr(16'h9800, 8'h55);
    PPU_MODE = H_BLANK;
    cpu_rd_req(16'h9800, 8'h5A, "draw_wr_dropped"); tick();
    PPU_MODE = DRAW;
    cpu_rd_req(16'h8001, 8'hFF, "draw_cpu_vram_rd"); tick();
    PPU_MODE = H_BLANK;
    cpu_wr(16'h9800, 8'h55);
    cpu_rd_req(16'h9800, 8'h55, "hblank_wr_rdback"); tick();
    PPU_MODE = V_BLANK;
    cpu_rd_req(16'hFE9F, 8'hA5, "vblank_oam_rd"); tick();
    PPU_MODE = H_BLANK;

    // Full transfer from C000
    dma_start(8'hC0);
    check_val("dma_start_active", {15'h0, DMA_ACTIVE}, 16'h1);
    cpu_rd_req(16'hFE10, 8'hFF, "cpu_oam_during_dma"); tick();
    check_val("dma_rd_strobe", {15'h0, DMA_RD}, 16'h1);
    check_val("dma_rd_src", DMA_SRC_ADDR, 16'hC000);
    check_val("dma_rd_no_owner_we", {15'h0, MEM_WE}, 16'h0);
    check_val("dma_rd_no_owner_addr", MEM_ADDR, 16'h0);
    cpu_rd_req(16'h8000, 8'h5A, "cpu_vram_during_dma"); tick();
    check_val("dma_wr_we", {15'h0, MEM_WE}, 16'h1);
    check_val("dma_wr_addr", MEM_ADDR, 16'hFE00);
    check_val("dma_wr_data", {8'h00, MEM_WDATA}, {8'h00, src_fn(16'hC000)});
    PPU_MODE = SCAN;
    ppu_rd_req(16'hFE00, 8'hFF, "ppu_oam_during_dma"); tick();
    PPU_MODE = DRAW;
    ppu_rd_req(16'h8002, 8'h58, "ppu_vram_during_dma"); tick();
    PPU_MODE = H_BLANK;
    while (dcyc < 321) tick();
    check_val("dma_active_c321", {15'h0, DMA_ACTIVE}, 16'h1);
    tick();
    check_val("dma_active_c322", {15'h0, DMA_ACTIVE}, 16'h0);
    check_oam(8'hC0, "oam_c0");

    // Restart with a new source at index 50
    dma_start(8'hC0);
    while (dcyc < 102) tick();
    check_val("restart_idx50_src", DMA_SRC_ADDR, 16'hC032);
    dma_start(8'hD0);
    check_val("restart_active", {15'h0, DMA_ACTIVE}, 16'h1);
    while (dcyc < 321) tick();
    check_val("restart_active_c321", {15'h0, DMA_ACTIVE}, 16'h1);
    tick();
    check_val("restart_active_c322", {15'h0, DMA_ACTIVE}, 16'h0);
    check_oam(8'hD0, "oam_d0");

    // Restart coinciding with the final write of a transfer
    dma_start(8'hE0);
    while (dcyc < 321) tick();
    check_val("final_wr_addr", MEM_ADDR, 16'hFE9F);
    dma_start(8'hC0);
    check_val("final_wr_done", {8'h00, mem[16'hFE9F]}, {8'h00, src_fn(16'hE09F)});
    check_val("coincide_active", {15'h0, DMA_ACTIVE}, 16'h1);
    check_val("coincide_src", DMA_SRC_ADDR, 16'hC000);
    tick();
    cpu_rd_req(16'h8002, 8'h58, "cpu_vram_before_abort"); tick();
    while (dcyc < 162) tick();
    check_val("abort_idx80_src", DMA_SRC_ADDR, 16'hC050);

    // Asynchronous reset mid-transfer
    rst = 1'b0;
    #1;
    check_val("abort_dma_active", {15'h0, DMA_ACTIVE}, 16'h0);
    check_val("abort_dma_rd", {15'h0, DMA_RD}, 16'h0);
    check_val("abort_mem_we", {15'h0, MEM_WE}, 16'h0);
    check_val("abort_mem_addr", MEM_ADDR, 16'h0);
    check_val("abort_mem_wdata", {8'h00, MEM_WDATA}, 16'h0);
    check_val("abort_src_addr", DMA_SRC_ADDR, 16'h0);
    check_val("abort_cpu_data", {8'h00, CPU_DATA_in}, 16'h00FF);
    check_val("abort_ppu_data", {8'h00, PPU_DATA_in}, 16'h00FF);
    repeat (3) tick();
    rst = 1'b1;
    repeat (4) tick();
    check_val("post_abort_idle", {15'h0, DMA_ACTIVE}, 16'h0);
    for (int i = 0; i < 160; i++) begin
      logic [7:0] e;
      e = (i < 80) ? src_fn({8'hC0, 8'(i)}) : src_fn({8'hE0, 8'(i)});
      check_val("oam_after_abort", {8'h00, mem[16'hFE00 + 16'(i)]}, {8'h00, e});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
